// File: rtl/conv_8_1_pkg.sv
// Shared PHY transmit definitions: idle/sync symbol and serializer state encoding.
// The receive-side aligner uses the same values.
package conv_8_1_pkg;

  localparam logic [7:0] ComSym = 8'hBC;

  typedef enum logic {
    StSync   = 1'b0,
    StActive = 1'b1
  } conv_state_e;

endpackage

// File: rtl/conv_8_1.sv
// Byte-to-serial converter: loads one byte every 8 clk_32f cycles and shifts it out MSB first.
// Idle slots carry COM_SYM, and a COM preamble of MIN_COM bytes follows every reset.
module conv_8_1
  import conv_8_1_pkg::*;
#(
  parameter logic [7:0]  COM_SYM = ComSym,
  parameter int unsigned MIN_COM = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       byte_req,
  output logic       data_out,
  output logic       active
);

  // One extra bit so MIN_COM=1 still gets a non-zero-width counter.
  localparam int unsigned       CntW    = $clog2(MIN_COM) + 1;
  localparam logic [CntW-1:0]   ComLast = CntW'(MIN_COM - 1);

  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      next_byte;
  logic [CntW-1:0] com_cnt_q, com_cnt_d;
  conv_state_e     state_q, state_d;
  logic            boundary;

  assign boundary = (bit_cnt_q == 3'd7);
  assign byte_req = boundary;
  assign data_out = shift_q[7];

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q <= 3'd7;
      shift_q   <= 8'h00;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      shift_q   <= boundary ? next_byte : {shift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StSync;
      com_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    if (boundary) begin
      unique case (state_q)
        StSync: begin
          if (com_cnt_q == ComLast) begin
            state_d = StActive;
          end else begin
            com_cnt_d = com_cnt_q + CntW'(1);
          end
        end
        StActive: state_d = StActive;
        default:  state_d = StSync;
      endcase
    end
  end

  // Gating on valid_in keeps an undriven data_in off the lane.
  always_comb begin
    active    = (state_q == StActive);
    next_byte = COM_SYM;
    if ((state_q == StActive) && valid_in) begin
      next_byte = data_in;
    end
  end

endmodule

// File: tb/tb_conv_8_1.sv
// Scoreboard bench for conv_8_1: the driver pushes the byte each slot should carry,
// the monitor reassembles serial bytes and checks them against the queue.
module tb_conv_8_1;

  localparam int unsigned MinCom = 4;
  localparam logic [7:0]  Com    = 8'hBC;

  logic       clk_32f;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       byte_req;
  logic       data_out;
  logic       active;

  int         checks;
  int         errors;
  int         edge_n;
  int         idx;
  logic [7:0] acc;
  logic       unk;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  conv_8_1 #(
    .COM_SYM(Com),
    .MIN_COM(MinCom)
  ) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .data_in (data_in),
    .valid_in(valid_in),
    .byte_req(byte_req),
    .data_out(data_out),
    .active  (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // Rising edges since reset release; edge 1 is the first byte boundary.
  always @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  // Monitor: one serial bit per negedge, full byte compared at the last bit.
  always @(negedge clk_32f) begin
    if (reset_L && edge_n > 0) begin
      idx = (edge_n - 1) % 8;
      if (idx == 0) begin
        acc = 8'h00;
        unk = 1'b0;
        chk("active", {31'd0, active}, {31'd0, edge_n >= int'(8 * MinCom - 7)});
      end
      acc = {acc[6:0], data_out};
      unk = unk | $isunknown(data_out);
      if (idx == 3) chk("byte_req_low", {31'd0, byte_req}, 32'd0);
      if (idx == 7) begin
        chk("byte_req_high", {31'd0, byte_req}, 32'd1);
        chk("data_out_known", {31'd0, unk}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          exp_b = exp_q.pop_front();
          chk("serial_byte", {24'd0, acc}, {24'd0, exp_b});
        end
      end
    end
  end

  // Drive one byte slot during the byte_req cycle and queue its expected lane content.
  task automatic slot(input logic v, input logic [7:0] d);
    int n;
    int s;
    n = 0;
    do begin
      @(negedge clk_32f);
      n++;
    end while ((edge_n % 8) != 0 && n < 16);
    if (n >= 16) chk("slot_timeout", 32'd1, 32'd0);
    valid_in = v;
    data_in  = d;
    s = edge_n / 8 + 1;
    if (s <= int'(MinCom) || !v) exp_q.push_back(Com);
    else                         exp_q.push_back(d);
  endtask

  task automatic do_release();
    @(posedge clk_32f);
    #2 reset_L = 1'b1;
  endtask

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk_32f);
    chk("rst_data_out", {31'd0, data_out}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_byte_req", {31'd0, byte_req}, 32'd1);
    do_release();

    // Preamble; valid data in the last SYNC slot must still be replaced by COM.
    slot(1'b0, 8'h00);
    slot(1'b0, 8'h00);
    slot(1'b0, 8'h00);
    slot(1'b1, 8'h55);
    // First honoured slot, then back-to-back data.
    slot(1'b1, 8'hA5);
    slot(1'b0, 8'h00);
    slot(1'b1, 8'hFF);
    slot(1'b1, 8'h00);
    slot(1'b1, 8'h3C);
    slot(1'b0, 8'h00);
    // valid_in pulse at bit_cnt=3 only.
    repeat (4) @(negedge clk_32f);
    valid_in = 1'b1;
    data_in  = 8'h11;
    @(negedge clk_32f);
    valid_in = 1'b0;
    slot(1'b0, 8'h11);
    slot(1'b0, 8'hxx);
    slot(1'b0, 8'hxx);

    // Reset in the middle of an A5 byte.
    slot(1'b1, 8'hA5);
    repeat (5) @(negedge clk_32f);
    #1 reset_L = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_data_out", {31'd0, data_out}, 32'd0);
    chk("midrst_active", {31'd0, active}, 32'd0);
    chk("midrst_byte_req", {31'd0, byte_req}, 32'd1);
    repeat (2) @(negedge clk_32f);
    do_release();
    slot(1'b1, 8'h77);
    slot(1'b1, 8'h77);
    slot(1'b1, 8'h77);
    slot(1'b1, 8'h77);
    slot(1'b1, 8'h5A);
    slot(1'b0, 8'h00);

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_32f);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
